// File: rtl/fifo_stream_reader.sv
// Read-side controller for the linear synchronous FIFO: pops words and re-presents them as a
// valid/ready stream via a 3-entry holding buffer. Optional macro FIFO_READER_COUNT_EN adds rd_count.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  flush_done
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  logic [1:0]            state, state_nxt;
  logic                  inflight;
  logic [1:0]            occ, head, tail;
  logic [DATA_WIDTH-1:0] hold_mem [0:2];
  logic [2:0]            pending;
  logic                  pop, capture, flush_entry, flush_exit;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pending     = {1'b0, occ} + {2'b0, inflight};
    flush_entry = flush && (state != ST_FLUSH);
    flush_exit  = (state == ST_FLUSH) && fifo_empty && !inflight;
    m_valid     = (occ != 2'd0) && (state != ST_FLUSH);
    m_data      = hold_mem[head];
    pop         = m_valid && m_ready;
    // A word arriving while flushing, or on the flush edge itself, is dropped.
    capture     = inflight && (state != ST_FLUSH) && !flush_entry;

    // Issue depends only on registered terms, so m_ready never reaches fifo_rd_en.
    fifo_rd_en = 1'b0;
    case (state)
      ST_STREAM: fifo_rd_en = !fifo_empty && (pending < 3'd3);
      ST_FLUSH:  fifo_rd_en = !fifo_empty;
      default:   fifo_rd_en = 1'b0;
    endcase

    state_nxt = state;
    if (flush_entry) begin
      state_nxt = ST_FLUSH;
    end else begin
      case (state)
        ST_IDLE:   if (enable) state_nxt = ST_STREAM;
        ST_STREAM: if (!enable) state_nxt = ST_IDLE;
        ST_FLUSH:  if (flush_exit) state_nxt = enable ? ST_STREAM : ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      inflight   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      inflight   <= fifo_rd_en;
      flush_done <= flush_exit;
    end
  end

  // NOTE: the holding buffer is only three words, so it is reset to give a defined m_data of 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ  <= 2'd0;
      head <= 2'd0;
      tail <= 2'd0;
      for (int i = 0; i < 3; i++) hold_mem[i] <= '0;
    end else if (flush_entry) begin
      occ  <= 2'd0;
      head <= 2'd0;
      tail <= 2'd0;
    end else begin
      if (capture) begin
        hold_mem[tail] <= fifo_data_out;
        tail           <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      case ({capture, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_READER_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= 16'd0;
    end else if (flush_entry) begin
      rd_count <= 16'd0;
    end else if (pop && (rd_count != 16'hFFFF)) begin
      rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
